// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, REFUND} state_t;

  localparam int CREDIT_W = 4;

  localparam logic [CREDIT_W-1:0] COIN_A_VAL = 4'd1;
  localparam logic [CREDIT_W-1:0] COIN_B_VAL = 4'd2;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector; one pulse per 0->1.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // [0],[1] synchronise; [2] holds the previous synchronised level
  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign pulse = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: conditions buttons, accumulates credit, drives
// vend/change/reject strobes and the 4-bit credit digit for the display.
//
// state  | meaning
// IDLE   | no credit held, waiting for a coin
// CREDIT | credit held, accepting coins, buy or cancel
// VEND   | vend strobe active for VEND_CYCLES cycles
// REFUND | paying back remaining credit one unit per cycle
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = 5,
  parameter int MAX_CREDIT  = 8,
  parameter int VEND_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_a,
  input  logic                coin_b,
  input  logic                buy,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy
);

  localparam int CNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

  logic ev_a, ev_b, ev_buy, ev_cancel;

  edge_sync u_sync_a      (.clk(clk), .rst_n(rst_n), .din(coin_a), .pulse(ev_a));
  edge_sync u_sync_b      (.clk(clk), .rst_n(rst_n), .din(coin_b), .pulse(ev_b));
  edge_sync u_sync_buy    (.clk(clk), .rst_n(rst_n), .din(buy),    .pulse(ev_buy));
  edge_sync u_sync_cancel (.clk(clk), .rst_n(rst_n), .din(cancel), .pulse(ev_cancel));

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    vend_cnt_q, vend_cnt_d;
  logic                vend_q, vend_d;
  logic                change_q, change_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  logic                coin_ev;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;

  always_comb begin
    coin_ev  = ev_a | ev_b;
    coin_val = ev_b ? COIN_B_VAL : COIN_A_VAL;
    coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    vend_cnt_d = vend_cnt_q;
    change_d   = 1'b0;
    reject_d   = 1'b0;

    unique case (state_q)
      IDLE, CREDIT: begin
        if (ev_cancel) begin
          reject_d = coin_ev;
          if (state_q == CREDIT) begin
            if (credit_q != '0) begin
              state_d  = REFUND;
              credit_d = credit_q - 1'b1;
              change_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (ev_buy) begin
          reject_d = coin_ev;
          if (state_q == CREDIT && credit_q >= CREDIT_W'(PRICE)) begin
            state_d    = VEND;
            credit_d   = credit_q - CREDIT_W'(PRICE);
            vend_cnt_d = CNT_W'(VEND_CYCLES - 1);
          end
        end else if (coin_ev) begin
          // coin_a losing to coin_b in the same cycle is a rejected event
          reject_d = ev_a & ev_b;
          if (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT)) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      VEND: begin
        reject_d = coin_ev;
        if (vend_cnt_q == '0) begin
          if (credit_q != '0) begin
            state_d  = REFUND;
            credit_d = credit_q - 1'b1;
            change_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          vend_cnt_d = vend_cnt_q - 1'b1;
        end
      end

      REFUND: begin
        reject_d = coin_ev;
        if (credit_q != '0) begin
          credit_d = credit_q - 1'b1;
          change_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    vend_d = (state_d == VEND);
    busy_d = (state_d == VEND) || (state_d == REFUND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      vend_cnt_q <= '0;
      vend_q     <= 1'b0;
      change_q   <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      vend_cnt_q <= vend_cnt_d;
      vend_q     <= vend_d;
      change_q   <= change_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign vend         = vend_q;
  assign change_pulse = change_q;
  assign coin_reject  = reject_q;
  assign busy         = busy_q;

  // A wrapped decrement would show up as 15, so the cap also guards underflow;
  // the second check pins the step out of zero to at most one coin.
  a_credit_cap : assert property (@(posedge clk) disable iff (!rst_n)
    credit_q <= CREDIT_W'(MAX_CREDIT));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    ($past(credit_q) == '0) |-> (credit_q <= COIN_B_VAL));

endmodule
